// File: rtl/count_sequencer_if.sv
// Board-side bundle for count_sequencer: buttons, switches, counter
// handshake and status outputs.
interface count_sequencer_if;
  logic        start_btn;
  logic        stop_btn;
  logic        clear_btn;
  logic [1:0]  speed_sel;
  logic [15:0] max_count;
  logic        incremented;
  logic        signal;
  logic [63:0] delaySet;
  logic        counter_rst;
  logic [15:0] tally;
  logic [2:0]  state;
  logic        done;

  // Board / testbench side: drives buttons, switches and the counter pulse.
  modport master (
    output start_btn, stop_btn, clear_btn, speed_sel, max_count, incremented,
    input  signal, delaySet, counter_rst, tally, state, done
  );

  // Sequencer side.
  modport slave (
    input  start_btn, stop_btn, clear_btn, speed_sel, max_count, incremented,
    output signal, delaySet, counter_rst, tally, state, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Control FSM for the delay-based up-counter: turns start/stop/clear button
// edges and a speed switch into counter enable, delay setting and reset, and
// stops the counter exactly when the step tally reaches the latched target.
module count_sequencer #(
  parameter logic [63:0] DELAY_0      = 64'd100_000_000,
  parameter logic [63:0] DELAY_1      = 64'd50_000_000,
  parameter logic [63:0] DELAY_2      = 64'd10_000_000,
  parameter logic [63:0] DELAY_3      = 64'd1_000_000,
  parameter int          CLEAR_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  count_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  // Hold counter only needs to reach CLEAR_CYCLES-1.
  localparam int          CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  logic          start_q, stop_q, clear_q;
  logic          start_rise_s, stop_rise_s, clear_rise_s;
  logic [2:0]    state_q, state_d;
  logic [15:0]   tally_q, tally_d;
  logic [15:0]   target_q, target_d;
  logic [63:0]   delay_q, delay_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]   tally_inc_s;
  logic          signal_q, signal_d;
  logic          crst_q, crst_d;
  logic          done_q, done_d;

  // Zero-extended delay table lookup for the speed switch.
  function automatic logic [63:0] delay_lookup(input logic [1:0] sel);
    logic [63:0] d;
    case (sel)
      2'd0:    d = DELAY_0;
      2'd1:    d = DELAY_1;
      2'd2:    d = DELAY_2;
      2'd3:    d = DELAY_3;
      default: d = DELAY_0;
    endcase
    return d;
  endfunction

  assign start_rise_s = bus.start_btn & ~start_q;
  assign stop_rise_s  = bus.stop_btn  & ~stop_q;
  assign clear_rise_s = bus.clear_btn & ~clear_q;
  assign tally_inc_s  = tally_q + 16'd1;

  // State, datapath and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
      state_q   <= S_IDLE;
      tally_q   <= 16'd0;
      target_q  <= 16'd0;
      delay_q   <= DELAY_0;
      clr_cnt_q <= '0;
      signal_q  <= 1'b0;
      crst_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q   <= bus.start_btn;
      stop_q    <= bus.stop_btn;
      clear_q   <= bus.clear_btn;
      state_q   <= state_d;
      tally_q   <= tally_d;
      target_q  <= target_d;
      delay_q   <= delay_d;
      clr_cnt_q <= clr_cnt_d;
      signal_q  <= signal_d;
      crst_q    <= crst_d;
      done_q    <= done_d;
    end
  end

  // Next state with priority clear > target reached > stop > start.
  always_comb begin
    state_d   = state_q;
    tally_d   = tally_q;
    target_d  = target_q;
    delay_d   = delay_q;
    clr_cnt_d = clr_cnt_q;
    if (clear_rise_s) begin
      state_d   = S_CLEAR;
      tally_d   = 16'd0;
      target_d  = 16'd0;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise_s) begin
            target_d = bus.max_count;
            delay_d  = delay_lookup(bus.speed_sel);
            state_d  = (bus.max_count == 16'd0) ? S_DONE : S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.incremented) begin
            tally_d = tally_inc_s;
            if (tally_inc_s == target_q) begin
              state_d = S_DONE;
            end else if (stop_rise_s) begin
              state_d = S_PAUSE;
            end else begin
              state_d = S_RUN;
            end
          end else if (stop_rise_s) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (start_rise_s) begin
            delay_d = delay_lookup(bus.speed_sel);
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = S_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode of the upcoming state, registered alongside it.
  always_comb begin
    signal_d = 1'b0;
    crst_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_RUN:   signal_d = 1'b1;
      S_DONE:  done_d   = 1'b1;
      S_CLEAR: crst_d   = 1'b1;
      default: begin
        signal_d = 1'b0;
        crst_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  assign bus.signal      = signal_q;
  assign bus.delaySet    = delay_q;
  assign bus.counter_rst = crst_q;
  assign bus.tally       = tally_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomised + directed bench for count_sequencer with a cycle scoreboard:
// the driver updates a rule-level model at each edge and queues the expected
// outputs; an independent monitor pops and compares at the falling edge.
module tb_count_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_sequencer_if bus ();

  count_sequencer #(
    .DELAY_0(64'd4), .DELAY_1(64'd3), .DELAY_2(64'd2), .DELAY_3(64'd1),
    .CLEAR_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int          st;
    bit          sig;
    bit          crst;
    bit          dn;
    int          tal;
    logic [63:0] dly;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state (rule level: mode number, counts, table)
  int          m_mode;
  int          m_tally, m_target, m_clr_left;
  logic [63:0] m_delay;
  bit          m_ps, m_pp, m_pc;
  logic [63:0] delay_tab [4] = '{64'd4, 64'd3, 64'd2, 64'd1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  // One clock edge: advance the model with the inputs the DUT samples now.
  task automatic tick();
    exp_t e;
    bit sr, pr, cr;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_tally = 0; m_target = 0; m_clr_left = 0;
      m_delay = delay_tab[0];
      m_ps = 0; m_pp = 0; m_pc = 0;
    end else begin
      sr = bus.start_btn && !m_ps;
      pr = bus.stop_btn  && !m_pp;
      cr = bus.clear_btn && !m_pc;
      m_ps = bus.start_btn; m_pp = bus.stop_btn; m_pc = bus.clear_btn;
      if (cr) begin
        m_mode = 4; m_tally = 0; m_target = 0; m_clr_left = 2;
      end else if (m_mode == 0) begin
        if (sr) begin
          m_target = int'(bus.max_count);
          m_delay  = delay_tab[bus.speed_sel];
          m_mode   = (m_target == 0) ? 3 : 1;
        end
      end else if (m_mode == 1) begin
        if (bus.incremented) m_tally = m_tally + 1;
        if (m_tally == m_target) m_mode = 3;
        else if (pr) m_mode = 2;
      end else if (m_mode == 2) begin
        if (sr) begin
          m_delay = delay_tab[bus.speed_sel];
          m_mode  = 1;
        end
      end else if (m_mode == 4) begin
        m_clr_left = m_clr_left - 1;
        if (m_clr_left == 0) m_mode = 0;
      end
    end
    e.st = m_mode; e.sig = (m_mode == 1); e.crst = (m_mode == 4);
    e.dn = (m_mode == 3); e.tal = m_tally; e.dly = m_delay;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start(); bus.start_btn = 1'b1; tick(); bus.start_btn = 1'b0; tick(); endtask
  task automatic press_stop();  bus.stop_btn  = 1'b1; tick(); bus.stop_btn  = 1'b0; tick(); endtask
  task automatic press_clear(); bus.clear_btn = 1'b1; tick(); bus.clear_btn = 1'b0; ticks(3); endtask
  task automatic pulse_inc();   bus.incremented = 1'b1; tick(); bus.incremented = 1'b0; endtask

  // Monitor: compare whatever the DUT shows against the next queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state",       64'(bus.state),       64'(e.st));
        chk("signal",      64'(bus.signal),      64'(e.sig));
        chk("counter_rst", 64'(bus.counter_rst), 64'(e.crst));
        chk("done",        64'(bus.done),        64'(e.dn));
        chk("tally",       64'(bus.tally),       64'(e.tal));
        chk("delaySet",    bus.delaySet,         e.dly);
      end
    end
  end

  // Stimulus
  initial begin
    bus.start_btn = 1'b0; bus.stop_btn = 1'b0; bus.clear_btn = 1'b0;
    bus.speed_sel = 2'd0; bus.max_count = 16'd3; bus.incremented = 1'b0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();

    // Run to target 3 with pulses every 5 cycles
    press_start();
    for (int k = 0; k < 3; k++) begin ticks(4); pulse_inc(); end
    ticks(3);

    // Clear out of DONE, then a held start gives one RUN entry
    press_clear();
    bus.max_count = 16'd5;
    bus.start_btn = 1'b1; ticks(10); bus.start_btn = 1'b0; tick();
    pulse_inc(); tick();
    press_stop();
    pulse_inc(); tick();
    bus.speed_sel = 2'd3;
    press_start();
    ticks(2);

    // Stop and target-reaching increment in the same cycle
    press_clear();
    bus.max_count = 16'd2; bus.speed_sel = 2'd1;
    press_start();
    pulse_inc(); tick();
    bus.stop_btn = 1'b1; bus.incremented = 1'b1; tick();
    bus.stop_btn = 1'b0; bus.incremented = 1'b0; ticks(3);

    // Zero target, then clear+start together from IDLE
    press_clear();
    bus.max_count = 16'd0;
    press_start();
    ticks(2);
    press_clear();
    bus.max_count = 16'd4;
    bus.clear_btn = 1'b1; bus.start_btn = 1'b1; tick();
    bus.clear_btn = 1'b0; bus.start_btn = 1'b0; ticks(4);

    // Reset in the middle of a run at tally 5
    bus.max_count = 16'd8; bus.speed_sel = 2'd2;
    press_start();
    for (int k = 0; k < 5; k++) begin pulse_inc(); tick(); end
    rst = 1'b1; tick(); rst = 1'b0; ticks(2);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      bus.start_btn   = ($urandom_range(0, 5) == 0);
      bus.stop_btn    = ($urandom_range(0, 7) == 0);
      bus.clear_btn   = ($urandom_range(0, 24) == 0);
      bus.incremented = ($urandom_range(0, 3) == 0);
      bus.speed_sel   = 2'($urandom_range(0, 3));
      bus.max_count   = 16'($urandom_range(0, 5));
      rst             = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start_btn = 1'b0; bus.stop_btn = 1'b0; bus.clear_btn = 1'b0; bus.incremented = 1'b0;
    tick();

    // Drain scoreboard with a bounded wait
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/count_sequencer.md
# count_sequencer

Control FSM that sequences the lab's delay-based up-counter (the block with `signal`/`delaySet`/`incremented`/`count`). Turns debounced start/stop/clear buttons and a 2-bit speed switch into the counter's enable, delay setting and reset. It tallies `incremented` pulses against a latched target and stops the counter exactly at the target. Sits between the board I/O (buttons, switches, LEDs) and the counter instance.

## Interface
- `DELAY_0`, default 100_000_000: delaySet for speed_sel=0 (1 s per step at 100 MHz)
- `DELAY_1`, default 50_000_000: delaySet for speed_sel=1
- `DELAY_2`, default 10_000_000: delaySet for speed_sel=2
- `DELAY_3`, default 1_000_000: delaySet for speed_sel=3
- `CLEAR_CYCLES`, default 2: cycles `counter_rst` is held in CLEAR (≥1)

- `clk` in 1: system clock, 100 MHz, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start_btn` in 1: debounced level; rising edge = start/resume
- `stop_btn` in 1: debounced level; rising edge = pause
- `clear_btn` in 1: debounced level; rising edge = clear
- `speed_sel` in 2: selects DELAY_0..3
- `max_count` in 16: target step count, latched on start from IDLE
- `incremented` in 1: one-cycle step pulse from counter
- `signal` out 1: counter enable
- `delaySet` out 64: counter delay setting
- `counter_rst` out 1: synchronous reset to counter
- `tally` out 16: steps taken since last clear
- `state` out 3: IDLE=0, RUN=1, PAUSE=2, DONE=3, CLEAR=4
- `done` out 1: high while in DONE

## Operation
- Edge detect: register each button; rise = btn & ~btn_q. Only rising edges act; held buttons act once.
- Priority among same-cycle events: clear > target-reached > stop > start.
- IDLE: start rise → latch target=max_count, latch delaySet from speed_sel, go RUN. If max_count=0, go directly to DONE with tally=0.
- RUN: `signal`=1. Each `incremented` pulse: tally+1. If new tally == target → DONE. stop rise → PAUSE. start rise ignored.
- PAUSE: `signal`=0; tally and target kept. start rise → re-latch delaySet from current speed_sel, go RUN. stop rise ignored.
- DONE: `signal`=0, `done`=1. start/stop ignored; only clear leaves.
- CLEAR (from any state on clear rise): `counter_rst`=1, tally=0, target=0, hold exactly CLEAR_CYCLES cycles, then IDLE. Clear rise while in CLEAR restarts the hold count.
- `incremented` outside RUN is ignored (no tally change).
- Arithmetic: tally 16-bit, compare exact equality to target; tally never exceeds target, so no wrap. delaySet is a zero-extended 64-bit table lookup.
- speed_sel changes take effect only on the next RUN entry.

## Timing
- All outputs registered; Moore outputs decoded from the registered state.
- Button rise sampled at edge N → state updates at edge N; `signal`/`counter_rst`/`done` reflect the new state from edge N on. This gives 1 cycle from the first cycle btn is sampled high to `signal` high.
- `incremented` at edge N in RUN → tally updates at edge N. If the target is reached, `signal` is low after edge N; the counter sees at most the pulse already issued.
- stop rise and target-reaching `incremented` in the same cycle → DONE (tally counted).
- clear rise in the same cycle as anything → CLEAR.
- Reset values (rst high at an edge): state=IDLE, signal=0, counter_rst=0, done=0, tally=0, target=0, delaySet=DELAY_0, button history=0. Reset mid-RUN/CLEAR aborts immediately; the counter is reset by its own `rst`.

## Test plan
- Params DELAY_0..3=4,3,2,1. Reset, max_count=3, speed_sel=0, start pulse, drive `incremented` every 5 cycles → signal high 1 cycle after start; tally 1,2,3; after the 3rd pulse state=DONE, done=1, signal=0.
- RUN with tally=1: stop rise → PAUSE, signal=0. Inject `incremented` → tally stays 1. Set speed_sel=3, start → RUN with delaySet=1, tally=1.
- target=2, tally=1: stop rise and `incremented` in the same cycle → state=DONE, tally=2.
- In DONE: clear rise → counter_rst=1 for exactly 2 cycles, tally=0, then IDLE. Start held high for 10 cycles → single RUN entry.
- max_count=0, start → DONE immediately, signal never high. clear and start in the same cycle from IDLE → CLEAR.
- rst asserted mid-RUN (tally=5) → next cycle all outputs at reset values, delaySet=4.
